// File: rtl/lutram_read_seq.sv
// Burst reader for a registered-output distributed RAM: issues sequential addresses and
// streams the words through a 2-entry FIFO. Define LUTRAM_RDSEQ_STRIDE_EN to add a stride input.
module lutram_read_seq #(
  parameter int DATA = 72,
  parameter int ADDR = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [ADDR-1:0] base,
  input  logic [ADDR:0]   len,
`ifdef LUTRAM_RDSEQ_STRIDE_EN
  input  logic [ADDR-1:0] stride,
`endif
  output logic            busy,
  output logic            done,
  output logic [ADDR-1:0] ram_addr,
  input  logic [DATA-1:0] ram_dout,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DATA-1:0] out_data
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state, state_nx;
  logic [ADDR-1:0] addr_q, last_q, step_q;
  logic [ADDR:0]   rem_q;
  logic            inflight;
  logic [DATA-1:0] fifo [2];
  logic            wr_ptr, rd_ptr;
  logic [1:0]      count;
  logic [2:0]      occ;
  logic            accept, pop, issue, last_xfer;

  assign accept    = (state == IDLE) && start;
  assign out_valid = (count != 2'd0);
  assign out_data  = fifo[rd_ptr];
  assign pop       = out_valid && out_ready;

  // Occupancy counts this cycle's pop so a steady stream keeps one word per cycle
  // without ever exceeding the two FIFO slots.
  assign occ       = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign issue     = (state == RUN) && (occ < 3'd2);
  assign last_xfer = (state == DRAIN) && pop && (count == 2'd1) && !inflight;
  assign ram_addr  = issue ? addr_q : last_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && (len != '0)) state_nx = RUN;
      RUN:     if (issue && (rem_q == (ADDR+1)'(1))) state_nx = DRAIN;
      DRAIN:   if (last_xfer) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      last_q   <= '0;
      step_q   <= '0;
      rem_q    <= '0;
      inflight <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= (accept && (len == '0)) || last_xfer;
      inflight <= issue;
      if (accept) begin
        addr_q <= base;
        rem_q  <= len;
`ifdef LUTRAM_RDSEQ_STRIDE_EN
        step_q <= stride;
`else
        step_q <= ADDR'(1);
`endif
      end else if (issue) begin
        addr_q <= addr_q + step_q;
        last_q <= addr_q;
        rem_q  <= rem_q - (ADDR+1)'(1);
      end
    end
  end

  // RAM data is captured only in the cycle after an issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) fifo[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (inflight) begin
        fifo[wr_ptr] <= ram_dout;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_lutram_read_seq.sv
// Table-driven bench for lutram_read_seq with a RAM model holding mem[i]=i and
// an expected-word scoreboard queue; hand sequences cover len=0 and reset corners.
module tb_lutram_read_seq;
  localparam int DATA = 72;
  localparam int ADDR = 10;

  logic            clk = 1'b0;
  logic            reset, start, out_ready;
  logic [ADDR-1:0] base;
  logic [ADDR:0]   len;
`ifdef LUTRAM_RDSEQ_STRIDE_EN
  logic [ADDR-1:0] stride;
`endif
  logic            busy, done, out_valid;
  logic [ADDR-1:0] ram_addr;
  logic [DATA-1:0] ram_dout, out_data;

  int errors = 0;
  int checks = 0;
  logic [DATA-1:0] exp_q [$];

  typedef struct {
    int         base;
    int         len;
    int         stride;
    logic [7:0] pat;
    int         first;
    int         last;
    bit         poke;
  } vec_t;

  vec_t vecs [$];

  always #5 clk = ~clk;

  // Registered-output RAM, mem[i] = i.
  always @(posedge clk) ram_dout <= DATA'(ram_addr);

  lutram_read_seq #(.DATA(DATA), .ADDR(ADDR)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .len(len),
`ifdef LUTRAM_RDSEQ_STRIDE_EN
    .stride(stride),
`endif
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  task automatic chk(input string name, input logic [DATA-1:0] act, input logic [DATA-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic run_burst(input vec_t v);
    int              first_k = -1;
    int              done_k = -1;
    bit              stall = 0;
    bit              got_first = 0;
    logic            busy_at_done = 1'b1;
    logic [DATA-1:0] held = '0;
    logic [DATA-1:0] lastw = '0;
    logic [DATA-1:0] e;
    for (int i = 0; i < v.len; i++) exp_q.push_back(DATA'((v.base + i * v.stride) % 1024));
    @(negedge clk);
    start = 1'b1;
    base = ADDR'(v.base);
    len = (ADDR+1)'(v.len);
`ifdef LUTRAM_RDSEQ_STRIDE_EN
    stride = ADDR'(v.stride);
`endif
    out_ready = v.pat[0];
    for (int k = 0; k < v.len * 8 + 40; k++) begin
      @(negedge clk);
      start = v.poke && (k == 1);
      if (v.poke && k == 1) begin
        base = 10'd500;
        len = 11'd7;
      end
      out_ready = v.pat[k % 8];
      #1;
      if (stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, held);
      end
      if (out_valid && first_k < 0) first_k = k;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word actual=%0d required=none", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("word", out_data, e);
          if (!got_first) chk("first_word", out_data, DATA'(v.first));
          got_first = 1;
          lastw = out_data;
        end
      end
      stall = out_valid && !out_ready;
      held = out_data;
      if (done) begin
        done_k = k;
        busy_at_done = busy;
        break;
      end
    end
    chk("done_seen", done_k >= 0, 1);
    chk("busy_at_done", busy_at_done, 0);
    chk("words_left", exp_q.size(), 0);
    chk("last_word", lastw, DATA'(v.last));
    chk("addr_hold", ram_addr, DATA'(v.last));
    if (v.pat == 8'hFF) begin
      chk("first_latency", first_k, 2);
      chk("done_latency", done_k, v.len + 2);
    end
    @(negedge clk);
    #1;
    chk("done_pulse_end", done, 0);
    exp_q.delete();
  endtask

  initial begin
    bit seen;
    vecs.push_back('{4,    3,    1, 8'hFF,       4,    6,    0});
    vecs.push_back('{1022, 4,    1, 8'hFF,       1022, 1,    0});
    vecs.push_back('{0,    8,    1, 8'b10011001, 0,    7,    0});
    vecs.push_back('{100,  5,    1, 8'hFF,       100,  104,  1});
    vecs.push_back('{1023, 1,    1, 8'hFF,       1023, 1023, 0});
    vecs.push_back('{200,  6,    1, 8'b00000011, 200,  205,  0});
    vecs.push_back('{0,    1024, 1, 8'hFF,       0,    1023, 0});
`ifdef LUTRAM_RDSEQ_STRIDE_EN
    vecs.push_back('{0,    4,    3, 8'hFF,       0,    9,    0});
    stride = '0;
`endif

    reset = 1'b1; start = 1'b0; base = '0; len = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_data", out_data, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) run_burst(vecs[i]);

    // len = 0: done one cycle after start, no words, never busy
    @(negedge clk);
    start = 1'b1; base = 10'd9; len = '0;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      if (out_valid || busy || done) seen = 1;
    end
    chk("len0_quiet", seen, 0);

    // Reset on the third word of a len=10 burst aborts it
    @(negedge clk);
    start = 1'b1; base = '0; len = 11'd10; out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (out_valid && out_data == 72'd2) begin
        seen = 1;
        break;
      end
    end
    chk("abort_reached_word3", seen, 1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (out_valid || done) seen = 1;
    end
    chk("abort_quiet", seen, 0);
    run_burst('{0, 2, 1, 8'hFF, 0, 1, 0});

    // Reset wins over a simultaneous start
    @(negedge clk);
    reset = 1'b1; start = 1'b1; base = 10'd7; len = 11'd3;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    #1;
    chk("prio_busy", busy, 0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (out_valid || busy || done) seen = 1;
    end
    chk("prio_quiet", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
